// File: rtl/elevator_car.sv
// Behavioural stand-in for the elevator car and shaft. It follows the controller's
// direction and target commands, steps one floor per travel period and runs a timed door cycle.
module elevator_car #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8,
  parameter int INIT_FLOOR    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] motor,
  input  logic       dir_up,
  input  logic       dir_down,
  output logic [1:0] current_floor,
  output logic       moving,
  output logic       door_open,
  output logic       arrived,
  output logic       fault
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);
  localparam logic [1:0]    INIT_FLR    = 2'(INIT_FLOOR);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_DOOR   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          dir_is_up;
  logic          seg_conflict;

  logic       both_cmd;
  logic       up_cmd;
  logic       down_cmd;
  logic [1:0] next_floor;
  logic       at_arrival;
  logic       cmd_held;
  logic       end_of_travel;
  logic       stop_here;

  // Travel and door phases never overlap, so a single counter serves both.
  assign both_cmd      = dir_up & dir_down;
  assign up_cmd        = dir_up & ~dir_down;
  assign down_cmd      = dir_down & ~dir_up;
  assign next_floor    = dir_is_up ? current_floor + 2'd1 : current_floor - 2'd1;
  assign at_arrival    = (state == S_MOVING) && (cnt == TRAVEL_LAST);
  assign end_of_travel = dir_is_up ? (next_floor == 2'd3) : (next_floor == 2'd0);

  // A conflicting command anywhere in the segment counts as the latched direction being dropped.
  assign cmd_held  = !seg_conflict && (dir_is_up ? up_cmd : down_cmd);
  assign stop_here = (motor == 4'b0000) || motor[next_floor] || !cmd_held || end_of_travel;

  // NOTE: every register here is assigned with <= so all of them update together
  // from the values sampled at the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      current_floor <= INIT_FLR;
      cnt           <= '0;
      dir_is_up     <= 1'b1;
      seg_conflict  <= 1'b0;
      arrived       <= 1'b0;
      fault         <= 1'b0;
    end else begin
      arrived <= 1'b0;
      if (both_cmd) fault <= 1'b1;

      case (state)
        S_IDLE: begin
          if (up_cmd && current_floor != 2'd3) begin
            dir_is_up    <= 1'b1;
            cnt          <= '0;
            seg_conflict <= 1'b0;
            state        <= S_MOVING;
          end else if (down_cmd && current_floor != 2'd0) begin
            dir_is_up    <= 1'b0;
            cnt          <= '0;
            seg_conflict <= 1'b0;
            state        <= S_MOVING;
          end
        end

        S_MOVING: begin
          if (at_arrival) begin
            current_floor <= next_floor;
            arrived       <= 1'b1;
            cnt           <= '0;
            seg_conflict  <= 1'b0;
            if (stop_here) state <= S_DOOR;
          end else begin
            cnt <= cnt + CW'(1);
            if (both_cmd) seg_conflict <= 1'b1;
          end
        end

        S_DOOR: begin
          if (cnt == DOOR_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register, so both clear the instant reset asserts.
  assign moving    = (state == S_MOVING);
  assign door_open = (state == S_DOOR);

endmodule

// File: tb/tb_elevator_car.sv
// Scoreboard bench for elevator_car: trips push expected arrive/door events with
// floor and cycle stamps; a negedge monitor pops and compares them as the car reports them.
module tb_elevator_car;

  localparam int TRAVEL = 16;
  localparam int DOOR   = 8;

  localparam int EV_ARRIVE = 0;
  localparam int EV_OPEN   = 1;
  localparam int EV_CLOSE  = 2;

  typedef struct {
    int kind;
    int floor;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] motor;
  logic       dir_up;
  logic       dir_down;
  logic [1:0] current_floor;
  logic       moving;
  logic       door_open;
  logic       arrived;
  logic       fault;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  exp_floor = 0;
  logic door_q = 1'b0;
  ev_t sb[$];

  elevator_car #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .INIT_FLOOR(0)) dut (
    .clk(clk),
    .reset(reset),
    .motor(motor),
    .dir_up(dir_up),
    .dir_down(dir_down),
    .current_floor(current_floor),
    .moving(moving),
    .door_open(door_open),
    .arrived(arrived),
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int floor, input int at);
    ev_t e;
    e.kind  = kind;
    e.floor = floor;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_floor", int'(current_floor), e.floor);
      check("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (arrived) sb_pop(EV_ARRIVE);
      if (door_open && !door_q) sb_pop(EV_OPEN);
      if (!door_open && door_q) sb_pop(EV_CLOSE);
    end
    door_q <= door_open;
  end

  // One trip of n floors. Optionally override dir inputs at segment offset ev_at,
  // either held (ev_pulse=0) or for one cycle only (ev_pulse=1).
  task automatic trip(input bit up, input logic [3:0] mot, input int n,
                      input int ev_at, input logic ev_up, input logic ev_down,
                      input bit ev_pulse);
    int n0;
    int a;
    dir_up   = up;
    dir_down = !up;
    motor    = mot;
    n0 = cyc + 1;
    for (int k = 1; k <= n; k++)
      push_ev(EV_ARRIVE, up ? exp_floor + k : exp_floor - k, n0 + TRAVEL * k);
    exp_floor = up ? exp_floor + n : exp_floor - n;
    a = n0 + TRAVEL * n;
    push_ev(EV_OPEN, exp_floor, a);
    push_ev(EV_CLOSE, exp_floor, a + DOOR);
    @(negedge clk);
    check("moving_after_accept", moving, 1);
    while (cyc < a) begin
      if (ev_at >= 0 && cyc == n0 + ev_at) begin
        dir_up   = ev_up;
        dir_down = ev_down;
      end else if (ev_pulse && ev_at >= 0 && cyc == n0 + ev_at + 1) begin
        dir_up   = up;
        dir_down = !up;
      end
      @(negedge clk);
    end
    dir_up   = 1'b0;
    dir_down = 1'b0;
    motor    = 4'b0000;
    while (cyc < a + DOOR + 1) @(negedge clk);
    check("idle_moving", moving, 0);
    check("idle_door", door_open, 0);
    check("idle_floor", int'(current_floor), exp_floor);
  endtask

  task automatic end_limit(input bit up);
    dir_up   = up;
    dir_down = !up;
    motor    = 4'b1111;
    repeat (4) @(negedge clk);
    check("limit_moving", moving, 0);
    check("limit_fault", fault, 0);
    check("limit_floor", int'(current_floor), exp_floor);
    dir_up   = 1'b0;
    dir_down = 1'b0;
    motor    = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    motor    = 4'b0000;
    dir_up   = 1'b0;
    dir_down = 1'b0;
    #1;
    check("rst_floor", int'(current_floor), 0);
    check("rst_moving", moving, 0);
    check("rst_door", door_open, 0);
    check("rst_arrived", arrived, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    trip(1'b1, 4'b0010, 1, -1, 1'b0, 1'b0, 1'b0);   // 0 -> 1
    trip(1'b0, 4'b0001, 1, -1, 1'b0, 1'b0, 1'b0);   // 1 -> 0
    end_limit(1'b0);                                 // down at floor 0 ignored
    trip(1'b1, 4'b1000, 3, -1, 1'b0, 1'b0, 1'b0);   // 0 -> 3, no gaps
    end_limit(1'b1);                                 // up at floor 3 ignored
    trip(1'b0, 4'b0100, 1, -1, 1'b0, 1'b0, 1'b0);   // 3 -> 2
    trip(1'b0, 4'b0001, 1, 5, 1'b1, 1'b0, 1'b0);    // 2 -> 1, down dropped mid-segment
    trip(1'b1, 4'b0100, 1, -1, 1'b0, 1'b0, 1'b0);   // 1 -> 2

    dir_up   = 1'b1;
    dir_down = 1'b1;
    @(negedge clk);
    check("both_fault", fault, 1);
    check("both_moving", moving, 0);
    dir_up   = 1'b0;
    dir_down = 1'b0;
    @(negedge clk);
    check("both_still_idle", moving, 0);

    trip(1'b0, 4'b0001, 2, -1, 1'b0, 1'b0, 1'b0);   // 2 -> 0 after fault
    check("fault_sticky", fault, 1);
    trip(1'b1, 4'b1000, 1, 3, 1'b1, 1'b1, 1'b1);    // conflict mid-segment: stop at 1

    dir_up = 1'b1;
    motor  = 4'b1000;
    repeat (6) @(negedge clk);
    check("pre_reset_moving", moving, 1);
    reset = 1'b0;
    #1;
    check("async_rst_floor", int'(current_floor), 0);
    check("async_rst_moving", moving, 0);
    check("async_rst_door", door_open, 0);
    check("async_rst_arrived", arrived, 0);
    check("async_rst_fault", fault, 0);
    dir_up = 1'b0;
    motor  = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    exp_floor = 0;
    repeat (2) @(negedge clk);
    check("post_rst_floor", int'(current_floor), 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
